dct_pingpong_ctrl: RTL and testbench



---
 rtl/dct_pingpong_ctrl.sv | 129 ++++++++++++
 tb/tb_dct_pingpong_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dct_pingpong_ctrl.sv
// Ping-pong transpose-buffer controller for the 2D-DCT: fills one 8x8 bank while
// the other drains, generating all bank addresses, strobes and selects.
module dct_pingpong_ctrl #(
    parameter int unsigned TRANSPOSE = 1,
    parameter int unsigned BLK_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 wr_en,
    output logic                 wr_bank,
    output logic [2:0]           wr_row,
    output logic [2:0]           wr_col,
    output logic                 rd_en,
    output logic                 rd_bank,
    output logic [2:0]           rd_row,
    output logic [2:0]           rd_col,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 blk_done,
    output logic [BLK_CNT_W-1:0] blk_count,
    output logic [1:0]           full
);

    logic                 wr_bank_q, wr_bank_d;
    logic [2:0]           wr_row_q, wr_row_d, wr_col_q, wr_col_d;
    logic                 rd_bank_q, rd_bank_d;
    logic [2:0]           rd_row_q, rd_row_d, rd_col_q, rd_col_d;
    logic [1:0]           full_q, full_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic                 blk_done_q, blk_done_d;
    logic [BLK_CNT_W-1:0] blk_count_q, blk_count_d;
    logic                 wr_last, rd_last;

    assign in_ready  = enable & ~full_q[wr_bank_q];
    assign wr_en     = in_valid & in_ready;
    // A pending sample may only be replaced once it is accepted downstream.
    assign rd_en     = enable & full_q[rd_bank_q] & (~out_valid_q | out_ready);

    assign wr_last   = (wr_row_q == 3'd7) && (wr_col_q == 3'd7);
    assign rd_last   = (rd_row_q == 3'd7) && (rd_col_q == 3'd7);

    assign wr_bank   = wr_bank_q;
    assign wr_row    = wr_row_q;
    assign wr_col    = wr_col_q;
    assign rd_bank   = rd_bank_q;
    assign rd_row    = rd_row_q;
    assign rd_col    = rd_col_q;
    assign full      = full_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign blk_done  = blk_done_q;
    assign blk_count = blk_count_q;

    always_comb begin
        wr_bank_d = wr_bank_q;
        wr_row_d  = wr_row_q;
        wr_col_d  = wr_col_q;
        full_d    = full_q;
        if (wr_en) begin
            if (TRANSPOSE != 0) begin
                wr_row_d = wr_row_q + 3'd1;
                if (wr_row_q == 3'd7) wr_col_d = wr_col_q + 3'd1;
            end else begin
                wr_col_d = wr_col_q + 3'd1;
                if (wr_col_q == 3'd7) wr_row_d = wr_row_q + 3'd1;
            end
            if (wr_last) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end

        rd_bank_d  = rd_bank_q;
        rd_row_d   = rd_row_q;
        rd_col_d   = rd_col_q;
        out_last_d = out_last_q;
        if (rd_en) begin
            rd_col_d   = rd_col_q + 3'd1;
            if (rd_col_q == 3'd7) rd_row_d = rd_row_q + 3'd1;
            out_last_d = rd_last;
            // Never the bank set above: a write needs that bank not full.
            if (rd_last) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end
        end

        if (rd_en)          out_valid_d = 1'b1;
        else if (out_ready) out_valid_d = 1'b0;
        else                out_valid_d = out_valid_q;

        blk_done_d  = out_valid_q & out_ready & out_last_q;
        blk_count_d = blk_done_d ? blk_count_q + BLK_CNT_W'(1) : blk_count_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_bank_q   <= 1'b0;
            wr_row_q    <= '0;
            wr_col_q    <= '0;
            rd_bank_q   <= 1'b0;
            rd_row_q    <= '0;
            rd_col_q    <= '0;
            full_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            blk_done_q  <= 1'b0;
            blk_count_q <= '0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            wr_row_q    <= wr_row_d;
            wr_col_q    <= wr_col_d;
            rd_bank_q   <= rd_bank_d;
            rd_row_q    <= rd_row_d;
            rd_col_q    <= rd_col_d;
            full_q      <= full_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            blk_done_q  <= blk_done_d;
            blk_count_q <= blk_count_d;
        end
    end

endmodule

// File: tb/tb_dct_pingpong_ctrl.sv
// Bench for dct_pingpong_ctrl: a cycle model of the handshakes plus a bank-memory
// model whose transposed data is scoreboarded at the downstream handshake.
module tb_dct_pingpong_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        in_ready, wr_en, wr_bank, rd_en, rd_bank;
    logic        out_valid, out_last, blk_done;
    logic [2:0]  wr_row, wr_col, rd_row, rd_col;
    logic [15:0] blk_count;
    logic [1:0]  full;

    int checks = 0;
    int errors = 0;

    dct_pingpong_ctrl #(.TRANSPOSE(1), .BLK_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_row(wr_row), .wr_col(wr_col),
        .rd_en(rd_en), .rd_bank(rd_bank), .rd_row(rd_row), .rd_col(rd_col),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .blk_done(blk_done), .blk_count(blk_count), .full(full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model state, advanced once per cycle at the falling edge.
    logic [1:0]  m_full;
    logic        m_wb, m_rb, m_ov, m_last, m_bd;
    logic [5:0]  wcnt, rcnt;
    logic [15:0] m_cnt;
    int          sid;
    int          mem [128];
    int          rdata;
    int          sb [$];

    always @(negedge clk) begin
        logic m_ir, m_wr, m_rd, hs, new_bd;
        if (!rst) begin
            m_full = '0; m_wb = 1'b0; m_rb = 1'b0; m_ov = 1'b0; m_last = 1'b0;
            m_bd = 1'b0; wcnt = '0; rcnt = '0; m_cnt = '0; sb.delete();
        end else begin
            m_ir = enable & ~m_full[m_wb];
            m_wr = in_valid & m_ir;
            m_rd = enable & m_full[m_rb] & (~m_ov | out_ready);
            hs   = m_ov & out_ready;
            chk("in_ready", in_ready, m_ir);
            chk("wr_en", wr_en, m_wr);
            chk("rd_en", rd_en, m_rd);
            chk("out_valid", out_valid, m_ov);
            chk("out_last", out_last, m_last);
            chk("full", full, m_full);
            chk("blk_done", blk_done, m_bd);
            chk("blk_count", blk_count, m_cnt);

            if (hs) begin
                if (sb.size() == 0) chk("sb_underflow", 1, 0);
                else chk("data", rdata, sb.pop_front());
            end
            if (m_rd) begin
                chk("rd_addr", {rd_bank, rd_row, rd_col}, {m_rb, rcnt[5:3], rcnt[2:0]});
                rdata = mem[{rd_bank, rd_row, rd_col}];
            end
            if (m_wr) begin
                chk("wr_addr", {wr_bank, wr_row, wr_col}, {m_wb, wcnt[2:0], wcnt[5:3]});
                mem[{wr_bank, wr_row, wr_col}] = sid;
                if (wcnt == 6'd63)
                    for (int j = 0; j < 64; j++) sb.push_back(sid - 63 + (j % 8) * 8 + j / 8);
                sid++;
            end

            new_bd = hs & m_last;
            if (new_bd) m_cnt = m_cnt + 16'd1;
            m_bd = new_bd;
            if (m_rd) begin
                m_last = (rcnt == 6'd63);
                if (rcnt == 6'd63) begin
                    m_full[m_rb] = 1'b0;
                    m_rb = ~m_rb;
                end
                rcnt = rcnt + 6'd1;
            end
            if (m_rd)           m_ov = 1'b1;
            else if (out_ready) m_ov = 1'b0;
            if (m_wr) begin
                if (wcnt == 6'd63) begin
                    m_full[m_wb] = 1'b1;
                    m_wb = ~m_wb;
                end
                wcnt = wcnt + 6'd1;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic send(input int n, input int budget);
        int acc = 0;
        int cyc = 0;
        in_valid = 1'b1;
        while (acc < n && cyc < budget) begin
            @(negedge clk);
            if (wr_en) acc++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        chk("send_count", acc, n);
    endtask

    task automatic wait_cnt(input int target, input int budget, input string tag);
        int n = 0;
        @(negedge clk);
        while (blk_count != 16'(target) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, blk_count, target);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [2:0] hr, hc;
        sid = 0;
        rdata = 0;
        do_reset();
        @(negedge clk);
        chk("rst_idx", {wr_bank, wr_row, wr_col, rd_bank, rd_row, rd_col}, 0);
        @(posedge clk); #1;

        // Single block, free-flowing output.
        send(64, 64);
        wait_cnt(1, 200, "t1_blk_count");

        // Three back-to-back blocks: in_ready must never drop.
        do_reset();
        send(192, 192);
        wait_cnt(3, 300, "t2_blk_count");

        // Full backpressure: both banks fill, first sample parked.
        do_reset();
        out_ready = 1'b0;
        send(128, 200);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t3_full", full, 2'b11);
        chk("t3_in_ready", in_ready, 0);
        chk("t3_out_valid", out_valid, 1);
        chk("t3_rd_idx", {rd_row, rd_col}, {3'd0, 3'd1});
        @(posedge clk); #1 out_ready = 1'b1;
        wait_cnt(2, 400, "t3_blk_count");

        // Alternating backpressure during a drain.
        do_reset();
        out_ready = 1'b0;
        send(64, 80);
        for (int i = 0; i < 400 && blk_count == 16'd0; i++) begin
            @(posedge clk); #1 out_ready = ~out_ready;
        end
        out_ready = 1'b1;
        wait_cnt(1, 10, "t4_blk_count");

        // Reset mid-block discards partial data.
        do_reset();
        send(37, 40);
        do_reset();
        @(negedge clk);
        chk("t5_wr_idx", {wr_bank, wr_row, wr_col}, 0);
        chk("t5_full", full, 0);
        chk("t5_blk_count", blk_count, 0);
        @(posedge clk); #1;
        send(64, 64);
        wait_cnt(1, 200, "t5_blocks");
        repeat (80) @(posedge clk);
        @(negedge clk);
        chk("t5_one_block", blk_count, 1);
        @(posedge clk); #1;

        // Enable dropped mid-drain.
        do_reset();
        send(64, 64);
        for (int i = 0; i < 100 && rd_row != 3'd3; i++) @(negedge clk);
        @(posedge clk); #1 enable = 1'b0;
        @(negedge clk);
        hr = rd_row;
        hc = rd_col;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("t6_idx_hold", {rd_row, rd_col}, {hr, hc});
        chk("t6_rd_en", rd_en, 0);
        chk("t6_blk_count", blk_count, 0);
        @(posedge clk); #1 enable = 1'b1;
        wait_cnt(1, 200, "t6_resume");

        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
